wimax_derandomizer: RTL and testbench

- Receive-side PRBS derandomizer for the 802.16 OFDM chain; sits after the FEC decoder and before the MAC burst sink.
- Removes the transmit-side 1+x^14+x^15 randomizing byte-wide, eight LFSR steps per clock. Reseeds at every burst start.
- Forwards exactly payload_len bytes per burst and silently consumes the trailing pad bytes.
- Ready/valid on both sides; one output register stage.

---
 rtl/wimax_derandomizer_if.sv | 28 ++
 rtl/wimax_derandomizer.sv | 129 ++++++++++++
 tb/tb_wimax_derandomizer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wimax_derandomizer_if.sv
// Byte-stream bus for the derandomizer. The input side carries the burst descriptor
// that travels with in_sob, and the output side is a plain ready/valid byte stream.
interface wimax_derandomizer_if #(
  parameter int LEN_W = 12
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_sob;
  logic [LEN_W-1:0] burst_len;
  logic [LEN_W-1:0] payload_len;
  logic [14:0]      seed;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_sob;
  logic             out_eob;
  logic             out_ready;

  modport master (
    output in_data, in_valid, in_sob, burst_len, payload_len, seed, out_ready,
    input  in_ready, out_data, out_valid, out_sob, out_eob
  );

  modport slave (
    input  in_data, in_valid, in_sob, burst_len, payload_len, seed, out_ready,
    output in_ready, out_data, out_valid, out_sob, out_eob
  );
endinterface

// File: rtl/wimax_derandomizer.sv
// Byte-wide 1+x^14+x^15 PRBS derandomizer, reseeded at each burst start.
// Forwards payload_len bytes per burst and swallows the trailing pad bytes.
module wimax_derandomizer #(
  parameter int LEN_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  wimax_derandomizer_if.slave  bus,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, DATA, PAD} state_t;

  state_t           state_reg;
  logic [14:0]      lfsr_reg;
  logic [LEN_W-1:0] rem_burst_reg;
  logic [LEN_W-1:0] rem_pay_reg;
  logic [7:0]       out_data_reg;
  logic             out_valid_reg;
  logic             out_sob_reg;
  logic             out_eob_reg;
  logic             err_reg;

  logic             accept;
  logic             start_ok;
  logic [14:0]      lfsr_base;
  logic [LEN_W-1:0] pay_clip;
  logic [7:0]       ks;
  logic [7:0]       descr;
  logic [14:0]      v [0:8];

  // In IDLE the first byte of a burst must use the incoming seed, not the stale register.
  assign lfsr_base = (state_reg == IDLE) ? bus.seed : lfsr_reg;
  assign v[0]      = lfsr_base;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_step
      assign ks[7-gi]    = v[gi][14] ^ v[gi][13];
      assign descr[7-gi] = bus.in_data[7-gi] ^ ks[7-gi];
      assign v[gi+1]     = {v[gi][13:0], ks[7-gi]};
    end
  endgenerate

  assign start_ok = bus.in_sob && (bus.burst_len != '0);
  assign pay_clip = (bus.payload_len > bus.burst_len) ? bus.burst_len : bus.payload_len;

  // Pad bytes never touch the output register, so they may flow even when it is stalled.
  assign bus.in_ready = (state_reg == PAD) | ~out_valid_reg | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sob   = out_sob_reg;
  assign bus.out_eob   = out_eob_reg;
  assign busy          = (state_reg != IDLE);
  assign err           = err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      lfsr_reg      <= '0;
      rem_burst_reg <= '0;
      rem_pay_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sob_reg   <= 1'b0;
      out_eob_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (accept) begin
        case (state_reg)
          IDLE: begin
            if (!start_ok) begin
              err_reg <= 1'b1;
            end else begin
              lfsr_reg      <= v[8];
              rem_burst_reg <= bus.burst_len - LEN_W'(1);
              if (pay_clip != '0) begin
                out_data_reg  <= descr;
                out_valid_reg <= 1'b1;
                out_sob_reg   <= 1'b1;
                out_eob_reg   <= (pay_clip == LEN_W'(1));
                rem_pay_reg   <= pay_clip - LEN_W'(1);
              end else begin
                rem_pay_reg   <= '0;
              end
              if (bus.burst_len == LEN_W'(1)) begin
                state_reg <= IDLE;
              end else if (pay_clip > LEN_W'(1)) begin
                state_reg <= DATA;
              end else begin
                state_reg <= PAD;
              end
            end
          end
          DATA: begin
            err_reg       <= bus.in_sob;
            lfsr_reg      <= v[8];
            out_data_reg  <= descr;
            out_valid_reg <= 1'b1;
            out_sob_reg   <= 1'b0;
            out_eob_reg   <= (rem_pay_reg == LEN_W'(1));
            rem_burst_reg <= rem_burst_reg - LEN_W'(1);
            rem_pay_reg   <= rem_pay_reg - LEN_W'(1);
            if (rem_pay_reg == LEN_W'(1)) begin
              state_reg <= (rem_burst_reg == LEN_W'(1)) ? IDLE : PAD;
            end
          end
          PAD: begin
            err_reg       <= bus.in_sob;
            lfsr_reg      <= v[8];
            rem_burst_reg <= rem_burst_reg - LEN_W'(1);
            if (rem_burst_reg == LEN_W'(1)) begin
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wimax_derandomizer.sv
// Randomized bench for wimax_derandomizer: a sequence-level PRBS model predicts every
// forwarded byte, and a monitor checks beats, stall stability and error pulses.
module tb_wimax_derandomizer;
  localparam int LEN_W = 12;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic err;

  wimax_derandomizer_if #(.LEN_W(LEN_W)) bus ();

  wimax_derandomizer #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sob;
    logic       eob;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  beat_t       exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  ks_q[$];
  int          exp_err = 0;
  int          err_seen = 0;
  int          ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 held low
  int          first_wait;
  bit          stall_prev = 0;
  beat_t       held;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Keystream from the sequence recurrence x[n] = x[n-15] ^ x[n-14]; the first 15
  // entries are the seed, oldest (bit 14) first.
  function automatic void gen_ks(input logic [14:0] sd, input int nbytes);
    bit bits[$];
    logic [7:0] b;
    ks_q.delete();
    for (int j = 0; j < 15; j++) bits.push_back(sd[14-j]);
    for (int n = 15; n < 15 + 8 * nbytes; n++) bits.push_back(bits[n-15] ^ bits[n-14]);
    for (int m = 0; m < nbytes; m++) begin
      for (int t = 0; t < 8; t++) b[7-t] = bits[15 + 8*m + t];
      ks_q.push_back(b);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ~bus.out_ready;
      2: bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (err) err_seen++;
      if (stall_prev) begin
        check_val("hold_valid", 32'(bus.out_valid), 32'd1);
        check_val("hold_beat", 32'({bus.out_data, bus.out_sob, bus.out_eob}), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          check_val("beat", 32'({bus.out_data, bus.out_sob, bus.out_eob}), 32'(exp_q.pop_front()));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = {bus.out_data, bus.out_sob, bus.out_eob};
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic sob, input int blen, input int plen,
                           input logic [14:0] sd, output int waits);
    bus.in_data     = d;
    bus.in_valid    = 1'b1;
    bus.in_sob      = sob;
    bus.burst_len   = LEN_W'(blen);
    bus.payload_len = LEN_W'(plen);
    bus.seed        = sd;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 200) begin
        check_val("accept_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sob   = 1'b0;
  endtask

  task automatic send_burst(input logic [14:0] sd, input int blen, input int plen, input int sob_err_idx);
    int w;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == 0) begin
        send_byte(tx_q[0], 1'b1, blen, plen, sd, w);
        first_wait = w;
      end else begin
        send_byte(tx_q[i], 1'(i == sob_err_idx), int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 4095)), 15'($urandom), w);
      end
    end
  endtask

  task automatic run_burst(input logic [14:0] sd, input int blen, input int plen, input int sob_err_idx);
    int pay;
    pay = (plen > blen) ? blen : plen;
    gen_ks(sd, blen);
    for (int m = 0; m < pay; m++)
      exp_q.push_back(beat_t'{d: tx_q[m] ^ ks_q[m], sob: 1'(m == 0), eob: 1'(m == pay - 1)});
    if (sob_err_idx > 0) exp_err++;
    send_burst(sd, blen, plen, sob_err_idx);
  endtask

  task automatic fill_random(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_val({tag, "_drain_timeout"}, 32'(n), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_err_count"}, 32'(err_seen), 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1);
  end

  initial begin
    int w;
    int blen;
    int plen;
    logic [14:0] sd;
    logic [7:0] orig[$];

    reset = 1'b1;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_sob = 1'b0;
    bus.burst_len = '0; bus.payload_len = '0; bus.seed = '0; bus.out_ready = 1'b1;
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_data", 32'(bus.out_data), 32'd0);
    check_val("rst_out_sob", 32'(bus.out_sob), 32'd0);
    check_val("rst_out_eob", 32'(bus.out_eob), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Known keystream from seed 4000: 80 then 03
    exp_q.push_back(beat_t'{d: 8'h80, sob: 1'b1, eob: 1'b0});
    exp_q.push_back(beat_t'{d: 8'h03, sob: 1'b0, eob: 1'b1});
    send_byte(8'h00, 1'b1, 2, 2, 15'h4000, w);
    check_val("ks_busy_mid", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b0, 0, 0, 15'h0, w);
    check_val("ks_busy_end", 32'(busy), 32'd0);
    drain("keystream");

    // Pad strip with the output stalled: pad beats must still flow
    exp_q.push_back(beat_t'{d: 8'h80, sob: 1'b1, eob: 1'b1});
    send_byte(8'h00, 1'b1, 4, 1, 15'h4000, w);
    ready_mode = 3;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h00, 1'b0, 0, 0, 15'h0, w);
      check_val("pad_ready", 32'(w), 32'd0);
    end
    check_val("pad_busy_end", 32'(busy), 32'd0);
    ready_mode = 0;
    drain("pad");
    fill_random(3);
    run_burst(15'($urandom), 3, 3, -1);
    drain("reseed");

    // Backpressure: randomize originals as the transmitter would, expect them back
    ready_mode = 1;
    sd = 15'($urandom);
    gen_ks(sd, 16);
    orig.delete(); tx_q.delete();
    for (int m = 0; m < 16; m++) begin
      orig.push_back(8'($urandom));
      tx_q.push_back(orig[m] ^ ks_q[m]);
      exp_q.push_back(beat_t'{d: orig[m], sob: 1'(m == 0), eob: 1'(m == 15)});
    end
    send_burst(sd, 16, 16, -1);
    drain("backpressure");

    // Random bursts under random backpressure
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      blen = int'($urandom_range(1, 20));
      plen = int'($urandom_range(0, 24));
      fill_random(blen);
      run_burst(15'($urandom), blen, plen, -1);
    end
    drain("random");
    ready_mode = 0;

    // Errors
    exp_err++;
    send_byte(8'h55, 1'b0, 4, 4, 15'h1234, w);
    drain("nosob");
    exp_err++;
    send_byte(8'h55, 1'b1, 0, 0, 15'h1234, w);
    check_val("blen0_idle", 32'(busy), 32'd0);
    drain("blen0");
    fill_random(6);
    run_burst(15'($urandom), 6, 6, 2);
    drain("sob_mid");

    // Back-to-back bursts
    fill_random(3);
    run_burst(15'($urandom), 3, 3, -1);
    exp_q.push_back(beat_t'{d: 8'h80, sob: 1'b1, eob: 1'b0});
    exp_q.push_back(beat_t'{d: 8'h03, sob: 1'b0, eob: 1'b1});
    tx_q.delete(); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    send_burst(15'h4000, 2, 2, -1);
    check_val("b2b_no_bubble", 32'(first_wait), 32'd0);
    drain("b2b");

    // Reset mid-DATA with a stalled output byte
    ready_mode = 3;
    bus.out_ready = 1'b0;
    send_byte(8'hA5, 1'b1, 8, 8, 15'h2AAA, w);
    check_val("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.in_data = 8'h3C; bus.in_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_out_data", 32'(bus.out_data), 32'd0);
    check_val("midrst_out_sob", 32'(bus.out_sob), 32'd0);
    check_val("midrst_out_eob", 32'(bus.out_eob), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    ready_mode = 0;
    bus.out_ready = 1'b1;
    fill_random(5);
    run_burst(15'($urandom), 5, 4, -1);
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
